// File: rtl/iir_ctrl_pkg.sv
// Shared state encoding and default widths for the IIR section sequencer.
package iir_ctrl_pkg;

    localparam int unsigned NSOS      = 5;
    localparam int unsigned NDWIDTH   = 18;
    localparam int unsigned NCNTWIDTH = 16;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_e;

endpackage

// File: rtl/iir_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module iir_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/iir_sos_sequencer.sv
// Sequences one input sample through Nsos second-order sections on a shared
// biquad engine, clearing all section state after reset or a flush request.
module iir_sos_sequencer
    import iir_ctrl_pkg::*;
#(
    parameter int unsigned Nsos      = NSOS,
    parameter int unsigned Ndwidth   = NDWIDTH,
    parameter int unsigned Ncntwidth = NCNTWIDTH,
    localparam int unsigned IdxW     = (Nsos > 1) ? $clog2(Nsos) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dv_in,
    input  logic signed [Ndwidth-1:0]   d_in,
    input  logic                        flush,
    output logic                        ready_out,
    output logic                        sec_start,
    output logic [IdxW-1:0]             sec_idx,
    output logic signed [Ndwidth-1:0]   sec_x,
    output logic                        state_clr,
    input  logic                        sec_done,
    input  logic signed [Ndwidth-1:0]   sec_y,
    output logic                        dv_out,
    output logic signed [Ndwidth-1:0]   d_out,
    output logic [Ncntwidth-1:0]        overrun_cnt
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(Nsos - 1);

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic signed [Ndwidth-1:0]  operand_q, operand_d;
    logic signed [Ndwidth-1:0]  d_out_q, d_out_d;
    logic                       ready_c;
    logic                       drop_c;

    assign ready_c = (state_q == ST_IDLE) || (state_q == ST_OUT);
    assign drop_c  = dv_in && (flush || !ready_c);

    // Next state; flush outranks both new samples and engine results.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        operand_d = operand_q;
        d_out_d   = d_out_q;
        if (flush) begin
            state_d = ST_FLUSH;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (idx_q == LastIdx) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                ST_IDLE, ST_OUT: begin
                    if (dv_in) begin
                        operand_d = d_in;
                        idx_d     = '0;
                        state_d   = ST_ISSUE;
                    end else if (state_q == ST_OUT) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (sec_done) begin
                        operand_d = sec_y;
                        if (idx_q == LastIdx) begin
                            d_out_d = sec_y;
                            state_d = ST_OUT;
                        end else begin
                            idx_d   = idx_q + IdxW'(1);
                            state_d = ST_ISSUE;
                        end
                    end
                end
                default: state_d = ST_FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FLUSH;
            idx_q     <= '0;
            operand_q <= '0;
            d_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            operand_q <= operand_d;
            d_out_q   <= d_out_d;
        end
    end

    // Strobes decode the state register and are held low while reset is asserted.
    assign ready_out = !reset && ready_c;
    assign sec_start = !reset && (state_q == ST_ISSUE);
    assign state_clr = !reset && (state_q == ST_FLUSH);
    assign dv_out    = !reset && (state_q == ST_OUT);
    assign sec_idx   = idx_q;
    assign sec_x     = operand_q;
    assign d_out     = d_out_q;

    iir_sat_counter #(
        .Width (Ncntwidth)
    ) u_overrun (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_c),
        .count (overrun_cnt)
    );

endmodule

// File: tb/tb_iir_sos_sequencer.sv
// Directed bench for iir_sos_sequencer with a 3-cycle engine model (y = x + 1).
module tb_iir_sos_sequencer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               dv_in = 1'b0;
    logic signed [17:0] d_in = '0;
    logic               flush = 1'b0;
    logic               spur = 1'b0;

    logic               ready_out, sec_start, state_clr, sec_done, dv_out;
    logic [2:0]         sec_idx;
    logic signed [17:0] sec_x, sec_y, d_out;
    logic [15:0]        overrun_cnt;

    logic               ready_out2, sec_start2, state_clr2, dv_out2;
    logic [2:0]         sec_idx2;
    logic signed [17:0] sec_x2, d_out2;
    logic [1:0]         overrun_cnt2;

    int errors = 0;
    int checks = 0;

    logic [2:0]         eng_p;
    logic signed [17:0] eng_y1, eng_y2, eng_y3;

    always #5 clk = ~clk;

    // Engine model: result three cycles after sec_start.
    always @(posedge clk) begin
        if (reset) begin
            eng_p <= '0;
        end else begin
            eng_p <= {eng_p[1:0], sec_start};
        end
        eng_y1 <= sec_x + 18'sd1;
        eng_y2 <= eng_y1;
        eng_y3 <= eng_y2;
    end

    assign sec_done = eng_p[2] | spur;
    assign sec_y    = eng_p[2] ? eng_y3 : 18'sd999;

    iir_sos_sequencer dut (
        .clk(clk), .reset(reset), .dv_in(dv_in), .d_in(d_in), .flush(flush),
        .ready_out(ready_out), .sec_start(sec_start), .sec_idx(sec_idx),
        .sec_x(sec_x), .state_clr(state_clr), .sec_done(sec_done), .sec_y(sec_y),
        .dv_out(dv_out), .d_out(d_out), .overrun_cnt(overrun_cnt)
    );

    iir_sos_sequencer #(.Ncntwidth(2)) dut2 (
        .clk(clk), .reset(reset), .dv_in(dv_in), .d_in(d_in), .flush(flush),
        .ready_out(ready_out2), .sec_start(sec_start2), .sec_idx(sec_idx2),
        .sec_x(sec_x2), .state_clr(state_clr2), .sec_done(sec_done), .sec_y(sec_y),
        .dv_out(dv_out2), .d_out(d_out2), .overrun_cnt(overrun_cnt2)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next(input logic dv, input logic signed [17:0] d,
                        input logic fl, input logic rst, input logic sp);
        @(posedge clk);
        #1;
        dv_in = dv;
        d_in  = d;
        flush = fl;
        reset = rst;
        spur  = sp;
        #1;
    endtask

    // Cycles k0..n after an accepted sample: start pulses and the single output strobe.
    task automatic follow(input int k0, input int n, input logic signed [63:0] dexp,
                          input logic signed [63:0] prev);
        for (int k = k0; k <= n; k++) begin
            next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
            chk("sec_start", 64'(sec_start), 64'((k % 4 == 1) && (k <= 17)));
            chk("dv_out", 64'(dv_out), 64'(k == n));
            if (k == n) chk("d_out", d_out, dexp);
            else if (k == n - 1) chk("d_out_hold", d_out, prev);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 5; i++) begin
            next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
            chk({tag, "_clr"}, 64'(state_clr), 64'd1);
            chk({tag, "_idx"}, 64'(sec_idx), 64'(i));
            chk({tag, "_dv"}, 64'(dv_out), 64'd0);
        end
        next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_ready"}, 64'(ready_out), 64'd1);
        chk({tag, "_clr_end"}, 64'(state_clr), 64'd0);
    endtask

    initial begin
        // Reset held: all strobes low, registers cleared.
        for (int i = 0; i < 3; i++) next(1'b0, 18'sd0, 1'b0, 1'b1, 1'b0);
        chk("rst_clr", 64'(state_clr), 64'd0);
        chk("rst_ready", 64'(ready_out), 64'd0);
        chk("rst_dv", 64'(dv_out), 64'd0);
        chk("rst_start", 64'(sec_start), 64'd0);
        chk("rst_dout", d_out, 64'sd0);
        chk("rst_cnt", 64'(overrun_cnt), 64'd0);

        // Post-reset sweep, with a dropped sample in every sweep cycle.
        for (int i = 0; i < 5; i++) begin
            next(1'b1, 18'sd3, 1'b0, 1'b0, 1'b0);
            chk("init_clr", 64'(state_clr), 64'd1);
            chk("init_idx", 64'(sec_idx), 64'(i));
            chk("init_ready", 64'(ready_out), 64'd0);
            chk("cnt", 64'(overrun_cnt), 64'(i));
            chk("cnt_sat2", 64'(overrun_cnt2), 64'((i > 3) ? 3 : i));
        end
        next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
        chk("init_ready_hi", 64'(ready_out), 64'd1);
        chk("init_clr_lo", 64'(state_clr), 64'd0);
        chk("cnt", 64'(overrun_cnt), 64'd5);
        chk("cnt_sat2", 64'(overrun_cnt2), 64'd3);

        // Single sample through five sections.
        next(1'b1, 18'sd100000, 1'b0, 1'b0, 1'b0);
        chk("accept_ready", 64'(ready_out), 64'd1);
        follow(1, 21, 64'sd100005, 64'sd0);

        // Samples every 7 cycles: two dropped, third accepted in OUT.
        next(1'b1, -18'sd1000, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            next(1'((k % 7) == 0), (k == 21) ? 18'sd2000 : 18'(k), 1'b0, 1'b0, 1'b0);
            if ((k % 7) == 0) chk("busy_ready", 64'(ready_out), 64'(k == 21));
            chk("p7_dv", 64'(dv_out), 64'(k == 21));
            if (k == 21) chk("p7_dout", d_out, -64'sd995);
        end
        follow(1, 21, 64'sd2005, -64'sd995);
        chk("cnt_p7", 64'(overrun_cnt), 64'd7);
        chk("cnt_sat2_p7", 64'(overrun_cnt2), 64'd3);

        // Flush mid-sample discards it and sweeps the section state.
        next(1'b1, 18'sd555, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
        next(1'b0, 18'sd0, 1'b1, 1'b0, 1'b0);
        chk("fl_dv", 64'(dv_out), 64'd0);
        sweep("flush");
        chk("fl_dout_held", d_out, 64'sd2005);
        next(1'b1, -18'sd5, 1'b0, 1'b0, 1'b0);
        chk("fl_accept", 64'(ready_out), 64'd1);
        follow(1, 21, 64'sd0, 64'sd2005);

        // Spurious engine strobes in IDLE and ISSUE are ignored.
        next(1'b0, 18'sd0, 1'b1, 1'b0, 1'b0);
        sweep("flush2");
        next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b1);
        chk("spur_idle_dv", 64'(dv_out), 64'd0);
        next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
        chk("spur_idle_idx", 64'(sec_idx), 64'd0);
        chk("spur_idle_ready", 64'(ready_out), 64'd1);
        chk("spur_idle_dv2", 64'(dv_out), 64'd0);
        next(1'b1, 18'sd7, 1'b0, 1'b0, 1'b0);
        next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b1);
        chk("spur_iss_start", 64'(sec_start), 64'd1);
        chk("spur_iss_x", sec_x, 64'sd7);
        next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
        chk("spur_iss_idx", 64'(sec_idx), 64'd0);
        chk("spur_iss_start2", 64'(sec_start), 64'd0);
        follow(3, 21, 64'sd12, 64'sd0);

        // Reset in the middle of a sample: no output, everything cleared.
        next(1'b1, 18'sd42, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            next(1'b0, 18'sd0, 1'b0, 1'b1, 1'b0);
            chk("mrst_dv", 64'(dv_out), 64'd0);
            chk("mrst_start", 64'(sec_start), 64'd0);
            chk("mrst_clr", 64'(state_clr), 64'd0);
        end
        sweep("mrst");
        chk("mrst_dout", d_out, 64'sd0);
        chk("mrst_cnt", 64'(overrun_cnt), 64'd0);
        for (int k = 0; k < 20; k++) begin
            next(1'b0, 18'sd0, 1'b0, 1'b0, 1'b0);
            chk("mrst_quiet", 64'(dv_out | sec_start), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
